multicycle_control: RTL and testbench

Multicycle control unit for the 4-bit-opcode datapath. It replaces the single-cycle opcode decoder with a registered state machine that sequences FETCH/DECODE/EXEC/MEM/WB. It stalls on a memory ready handshake, traps on memory timeout, and counts retired instructions. It sits between the instruction register and the datapath muxes, register file, ALU control and memory port.

---
 rtl/multicycle_control_pkg.sv | 46 ++++
 rtl/multicycle_control_if.sv | 56 +++++
 rtl/multicycle_control_opclass.sv | 35 +++
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pkg                                                                 |
// | Shared types and constants for the multicycle control unit: FSM state    |
// | encoding, opcode class encoding, opcode values and ALUOp encodings.      |
// | Ports: none (package).                                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_HALT    = 3'd5,
    CL_ILLEGAL = 3'd6
  } opclass_t;

  // Opcode values, right-aligned within the OPW-wide opcode field.
  localparam logic [3:0] OP_ATYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_BLT   = 4'b0100;
  localparam logic [3:0] OP_BGT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // {ALUOp1,ALUOp0}
  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_if                                                    |
// | Bundle between the instruction register / memory port and the control   |
// | unit. master = control unit side, slave = datapath side.                 |
// | Signals: opcode, funct, mem_ready (to control); PCWrite, IRWrite,        |
// | Branch, Jump, RegDst, MemtoReg, MemRead, MemWrite, ALUSrc, RegWrite,     |
// | ALUOp, halted, mem_err, instr_count (from control); illegal_op only when |
// | CTRL_ILLEGAL_TRAP_EN is defined.                                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface multicycle_control_if #(
  parameter int OPW  = 4,
  parameter int FNW  = 4,
  parameter int CNTW = 16
);
  logic [OPW-1:0]  opcode;
  logic [FNW-1:0]  funct;
  logic            mem_ready;
  logic            PCWrite;
  logic            IRWrite;
  logic            Branch;
  logic            Jump;
  logic            RegDst;
  logic            MemtoReg;
  logic            MemRead;
  logic            MemWrite;
  logic            ALUSrc;
  logic            RegWrite;
  logic [1:0]      ALUOp;
  logic            halted;
  logic            mem_err;
  logic [CNTW-1:0] instr_count;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic            illegal_op;
`endif

  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, IRWrite, Branch, Jump, RegDst, MemtoReg, MemRead,
           MemWrite, ALUSrc, RegWrite, ALUOp, halted, mem_err, instr_count
`ifdef CTRL_ILLEGAL_TRAP_EN
    , output illegal_op
`endif
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, IRWrite, Branch, Jump, RegDst, MemtoReg, MemRead,
           MemWrite, ALUSrc, RegWrite, ALUOp, halted, mem_err, instr_count
`ifdef CTRL_ILLEGAL_TRAP_EN
    , input illegal_op
`endif
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_opclass.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_opclass                                                             |
// | Combinational opcode classifier. Upper opcode bits beyond the 4-bit     |
// | constants must be zero for a match; anything unmatched is ILLEGAL.       |
// | Ports: i_op (OPW) opcode in, o_class (opclass_t) class out.              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ctrl_opclass
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] i_op,
  output opclass_t       o_class
);

  always_comb begin
    o_class = CL_ILLEGAL;
    if (i_op == OPW'(OP_ATYPE))
      o_class = CL_ALU;
    else if (i_op == OPW'(OP_LW))
      o_class = CL_LOAD;
    else if (i_op == OPW'(OP_SW))
      o_class = CL_STORE;
    else if (i_op == OPW'(OP_BLT) || i_op == OPW'(OP_BGT) || i_op == OPW'(OP_BEQ))
      o_class = CL_BRANCH;
    else if (i_op == OPW'(OP_JMP))
      o_class = CL_JUMP;
    else if (i_op == OPW'(OP_HALT))
      o_class = CL_HALT;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control                                                       |
// | FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready stall, timeout trap |
// | and retired-instruction counter.                                         |
// | Ports: clk, rst (async, active-high), bus (multicycle_control_if.master) |
// | Optional: CTRL_ILLEGAL_TRAP_EN - undefined opcodes halt and set          |
// | illegal_op instead of retiring as a NOP.                                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int FNW  = 4,
  parameter int TMO  = 16,
  parameter int CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus
);

  localparam logic [7:0] c_wait_last = 8'(TMO - 1);

  state_t          r_state, w_next;
  logic [OPW-1:0]  r_op;
  logic [OPW-1:0]  w_op_sel;
  opclass_t        w_class;
  logic [7:0]      r_wait;
  logic [CNTW-1:0] r_cnt;
  logic            r_mem_err;
  logic            w_retire;
  logic            w_waiting;
  logic            w_timeout;
  logic [FNW-1:0]  w_funct_unused;

  assign w_funct_unused = bus.funct;

  // DECODE has to branch on the live opcode (op_q is loaded on that same
  // edge); every other state classifies the latched copy, so the outputs
  // never see the opcode input combinationally.
  assign w_op_sel = (r_state == ST_DECODE) ? bus.opcode : r_op;

  ctrl_opclass #(.OPW(OPW)) u_opclass (
    .i_op    (w_op_sel),
    .o_class (w_class)
  );

  assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !bus.mem_ready;
  // Counter value TMO-1 marks the TMO-th waiting cycle; ready on that cycle wins.
  assign w_timeout = w_waiting && (r_wait == c_wait_last);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic w_illegal_set;
  logic r_illegal;
`endif

  // Next state and retire strobe
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_illegal_set = 1'b0;
`endif
    case (r_state)
      ST_FETCH: begin
        if (bus.mem_ready)  w_next = ST_DECODE;
        else if (w_timeout) w_next = ST_HALT;
      end
      ST_DECODE: begin
        case (w_class)
          CL_HALT: begin
            w_next   = ST_HALT;
            w_retire = 1'b1;
          end
          CL_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            w_next        = ST_HALT;
            w_illegal_set = 1'b1;
`else
            w_next   = ST_FETCH;
            w_retire = 1'b1;
`endif
          end
          default: w_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (w_class)
          CL_ALU:             w_next = ST_WB;
          CL_LOAD, CL_STORE:  w_next = ST_MEM;
          CL_BRANCH, CL_JUMP: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end
          default:            w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          if (w_class == CL_LOAD) begin
            w_next = ST_WB;
          end else begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end
        end else if (w_timeout) begin
          w_next = ST_HALT;
        end
      end
      ST_WB: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end

  // Datapath controls
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.Branch   = 1'b0;
    bus.Jump     = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUOp    = ALUOP_FUNCT;
    case (r_state)
      ST_FETCH: begin
        bus.MemRead = 1'b1;
        bus.PCWrite = bus.mem_ready;
        bus.IRWrite = bus.mem_ready;
      end
      ST_EXEC: begin
        case (w_class)
          CL_LOAD, CL_STORE: begin
            bus.ALUOp  = ALUOP_ADD;
            bus.ALUSrc = 1'b1;
          end
          CL_BRANCH: begin
            bus.Branch = 1'b1;
            bus.ALUOp  = ALUOP_CMP;
          end
          CL_JUMP: bus.Jump = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        bus.MemRead  = (w_class == CL_LOAD);
        bus.MemWrite = (w_class == CL_STORE);
      end
      ST_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = (w_class == CL_ALU);
        bus.MemtoReg = (w_class == CL_LOAD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_op      <= '0;
      r_wait    <= '0;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_op <= bus.opcode;
      // Any state change clears the counter, so entry to FETCH/MEM starts at 0.
      if (w_next != r_state) r_wait <= '0;
      else if (w_waiting)    r_wait <= r_wait + 8'd1;
      if (w_timeout) r_mem_err <= 1'b1;
      if (w_retire)  r_cnt     <= r_cnt + 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_illegal <= 1'b0;
    else if (w_illegal_set) r_illegal <= 1'b1;
  end
  assign bus.illegal_op = r_illegal;
`endif

  assign bus.halted      = (r_state == ST_HALT);
  assign bus.mem_err     = r_mem_err;
  assign bus.instr_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_control                                                    |
// | Directed self-checking bench for multicycle_control (TMO=16, CNTW=4).    |
// | Control vector order: {PCWrite,IRWrite,Branch,Jump,RegDst,MemtoReg,      |
// | MemRead,MemWrite,ALUSrc,RegWrite,ALUOp[1:0],halted,mem_err}.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_multicycle_control;

  localparam logic [13:0] E_FWAIT = 14'b0_0_0_0_0_0_1_0_0_0_00_0_0;
  localparam logic [13:0] E_FRDY  = 14'b1_1_0_0_0_0_1_0_0_0_00_0_0;
  localparam logic [13:0] E_DEC   = 14'b0_0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [13:0] E_EXA   = 14'b0_0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [13:0] E_EXMEM = 14'b0_0_0_0_0_0_0_0_1_0_10_0_0;
  localparam logic [13:0] E_EXBR  = 14'b0_0_1_0_0_0_0_0_0_0_01_0_0;
  localparam logic [13:0] E_EXJ   = 14'b0_0_0_1_0_0_0_0_0_0_00_0_0;
  localparam logic [13:0] E_MEMLW = 14'b0_0_0_0_0_0_1_0_0_0_00_0_0;
  localparam logic [13:0] E_MEMSW = 14'b0_0_0_0_0_0_0_1_0_0_00_0_0;
  localparam logic [13:0] E_WBA   = 14'b0_0_0_0_1_0_0_0_0_1_00_0_0;
  localparam logic [13:0] E_WBLW  = 14'b0_0_0_0_0_1_0_0_0_1_00_0_0;
  localparam logic [13:0] E_HALT  = 14'b0_0_0_0_0_0_0_0_0_0_00_1_0;
  localparam logic [13:0] E_HALTE = 14'b0_0_0_0_0_0_0_0_0_0_00_1_1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  multicycle_control_if #(.OPW(4), .FNW(4), .CNTW(4)) bus ();

  multicycle_control #(.OPW(4), .FNW(4), .TMO(16), .CNTW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] obs();
    return {bus.PCWrite, bus.IRWrite, bus.Branch, bus.Jump, bus.RegDst,
            bus.MemtoReg, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.RegWrite,
            bus.ALUOp, bus.halted, bus.mem_err};
  endfunction

  // Apply inputs, check controls mid-cycle, advance to the next falling edge.
  task automatic step(input string tag, input logic rdy, input logic [3:0] op,
                      input logic [13:0] exp);
    logic [13:0] o;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    #1;
    o = obs();
    n_cmp++;
    assert (o === exp) else begin
      n_bad++;
      $error("FAIL %s: ctrl observed %b expected %b", tag, o, exp);
    end
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] exp);
    n_cmp++;
    assert (bus.instr_count === exp) else begin
      n_bad++;
      $error("FAIL %s: instr_count observed %0d expected %0d", tag, bus.instr_count, exp);
    end
  endtask

  // Asynchronous reset: checked while rst is still high.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    n_cmp++;
    assert (obs() === E_FWAIT) else begin
      n_bad++;
      $error("FAIL %s: ctrl observed %b expected %b", tag, obs(), E_FWAIT);
    end
    check_cnt(tag, 4'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_cmp++;
    assert (bus.illegal_op === 1'b0) else begin
      n_bad++;
      $error("FAIL %s: illegal_op observed %b expected 0", tag, bus.illegal_op);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic jmp_instr(input string tag);
    step({tag, "_f"}, 1'b1, 4'b1100, E_FRDY);
    step({tag, "_d"}, 1'b1, 4'b1100, E_DEC);
    step({tag, "_x"}, 1'b1, 4'b1100, E_EXJ);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.opcode = 4'd0;
    bus.funct  = 4'd0;
    bus.mem_ready = 1'b0;
    do_reset("reset");

    // lw, zero wait: 5 cycles
    step("lw_fetch", 1'b1, 4'b1000, E_FRDY);
    step("lw_dec",   1'b1, 4'b1000, E_DEC);
    step("lw_exec",  1'b1, 4'b1000, E_EXMEM);
    step("lw_mem",   1'b1, 4'b1000, E_MEMLW);
    step("lw_wb",    1'b1, 4'b1000, E_WBLW);
    check_cnt("lw_cnt", 4'd1);

    // A-type, beq, jmp
    step("a_fetch", 1'b1, 4'b0000, E_FRDY);
    step("a_dec",   1'b1, 4'b0000, E_DEC);
    step("a_exec",  1'b1, 4'b0000, E_EXA);
    step("a_wb",    1'b1, 4'b0000, E_WBA);
    check_cnt("a_cnt", 4'd2);
    step("beq_fetch", 1'b1, 4'b0110, E_FRDY);
    step("beq_dec",   1'b1, 4'b0110, E_DEC);
    step("beq_exec",  1'b1, 4'b0110, E_EXBR);
    check_cnt("beq_cnt", 4'd3);
    jmp_instr("jmp1");
    check_cnt("jmp1_cnt", 4'd4);

    // sw with three wait cycles in MEM
    step("sw_fetch", 1'b1, 4'b1011, E_FRDY);
    step("sw_dec",   1'b1, 4'b1011, E_DEC);
    step("sw_exec",  1'b1, 4'b1011, E_EXMEM);
    for (int i = 0; i < 3; i++) step("sw_mem_wait", 1'b0, 4'b1011, E_MEMSW);
    check_cnt("sw_cnt_pending", 4'd4);
    step("sw_mem_done", 1'b1, 4'b1011, E_MEMSW);
    check_cnt("sw_cnt", 4'd5);

    // FETCH ready arrives on the 16th cycle: no trap
    for (int i = 0; i < 15; i++) step("f16_wait", 1'b0, 4'b1100, E_FWAIT);
    step("f16_ready", 1'b1, 4'b1100, E_FRDY);
    step("f16_dec",   1'b1, 4'b1100, E_DEC);
    step("f16_exec",  1'b1, 4'b1100, E_EXJ);
    check_cnt("f16_cnt", 4'd6);

    // undefined opcode 0011
    step("ill_fetch", 1'b1, 4'b0011, E_FRDY);
    step("ill_dec",   1'b1, 4'b0011, E_DEC);
`ifdef CTRL_ILLEGAL_TRAP_EN
    step("ill_halt", 1'b1, 4'b0011, E_HALT);
    check_cnt("ill_cnt", 4'd6);
    n_cmp++;
    assert (bus.illegal_op === 1'b1) else begin
      n_bad++;
      $error("FAIL ill_flag: illegal_op observed %b expected 1", bus.illegal_op);
    end
`else
    check_cnt("nop_cnt", 4'd7);
    step("nop_back_fetch", 1'b0, 4'b0011, E_FWAIT);
`endif
    do_reset("reset2");

    // 16 jmps with a 4-bit counter wrap to 0
    for (int i = 0; i < 15; i++) jmp_instr("wrap");
    check_cnt("wrap_15", 4'd15);
    jmp_instr("wrap16");
    check_cnt("wrap_0", 4'd0);
    jmp_instr("pre1");
    jmp_instr("pre2");
    check_cnt("pre_cnt", 4'd2);

    // reset while a lw waits in MEM
    step("ab_fetch", 1'b1, 4'b1000, E_FRDY);
    step("ab_dec",   1'b1, 4'b1000, E_DEC);
    step("ab_exec",  1'b1, 4'b1000, E_EXMEM);
    step("ab_mem",   1'b0, 4'b1000, E_MEMLW);
    do_reset("abort");
    jmp_instr("post_abort");
    check_cnt("post_abort_cnt", 4'd1);

    // FETCH timeout after 16 cycles
    for (int i = 0; i < 16; i++) step("to_wait", 1'b0, 4'b0000, E_FWAIT);
    for (int i = 0; i < 3; i++) step("to_halt", 1'b1, 4'b0000, E_HALTE);
    check_cnt("to_cnt", 4'd1);
    do_reset("reset3");

    // halt opcode: 2 cycles, retired
    step("h_fetch", 1'b1, 4'b1111, E_FRDY);
    step("h_dec",   1'b1, 4'b1111, E_DEC);
    step("h_halt",  1'b1, 4'b1111, E_HALT);
    check_cnt("h_cnt", 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
